// File: rtl/traceback_reader.sv
// rtl/traceback_reader.sv - Needleman-Wunsch score-matrix traceback walker
module traceback_reader #(
    parameter int N           = 128,
    parameter int BitAddr     = $clog2(N + 1),
    parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1),
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int GAP         = -2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ram_en,
    output logic [addr_lenght:0]    ram_addr,
    input  logic signed [8:0]       ram_dout,
    output logic [BitAddr:0]        addr_a,
    output logic [BitAddr:0]        addr_b,
    input  logic [1:0]              char_a,
    input  logic [1:0]              char_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_dir,
    output logic [BitAddr:0]        out_i,
    output logic [BitAddr:0]        out_j
);

    localparam int IW = BitAddr + 1;
    localparam int AW = addr_lenght + 1;

    localparam logic [1:0] DIR_DIAG = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_LEFT = 2'b11;

    localparam logic signed [9:0] MATCH_S    = 10'(MATCH);
    localparam logic signed [9:0] MISMATCH_S = 10'(MISMATCH);
    localparam logic signed [9:0] GAP_S      = 10'(GAP);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_CUR,
        ST_RD_DIAG,
        ST_RD_UP,
        ST_RD_LEFT,
        ST_WAIT,
        ST_DECIDE,
        ST_BORDER,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]     i;
    logic [IW-1:0]     j;
    logic [IW-1:0]     ni;
    logic [IW-1:0]     nj;
    logic [IW-1:0]     rd_i;
    logic [IW-1:0]     rd_j;
    logic signed [8:0] cur_r;
    logic signed [8:0] diag_r;
    logic signed [8:0] up_r;
    logic signed [8:0] left_r;
    logic              same_r;
    logic [1:0]        dir_r;
    logic [1:0]        dec_dir;
    logic              dec_err;

    logic signed [9:0] cur_x;
    logic signed [9:0] diag_x;
    logic signed [9:0] up_x;
    logic signed [9:0] left_x;
    logic signed [9:0] sub_x;

    assign cur_x  = {cur_r[8], cur_r};
    assign diag_x = {diag_r[8], diag_r};
    assign up_x   = {up_r[8], up_r};
    assign left_x = {left_r[8], left_r};
    assign sub_x  = same_r ? MATCH_S : MISMATCH_S;

    // Predecessor choice: diag, then up, then left; nothing matching falls back to left with an error
    always_comb begin
        dec_dir = DIR_LEFT;
        dec_err = 1'b1;
        if (cur_x == diag_x + sub_x) begin
            dec_dir = DIR_DIAG;
            dec_err = 1'b0;
        end else if (cur_x == up_x + GAP_S) begin
            dec_dir = DIR_UP;
            dec_err = 1'b0;
        end else if (cur_x == left_x + GAP_S) begin
            dec_dir = DIR_LEFT;
            dec_err = 1'b0;
        end
    end

    // Cell reached after the current step is accepted
    always_comb begin
        ni = i;
        nj = j;
        case (dir_r)
            DIR_DIAG: begin
                ni = i - IW'(1);
                nj = j - IW'(1);
            end
            DIR_UP:   ni = i - IW'(1);
            default:  nj = j - IW'(1);
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state read/stream outputs
    always_comb begin
        state_next = state;
        ram_en     = 1'b0;
        rd_i       = '0;
        rd_j       = '0;
        addr_a     = '0;
        addr_b     = '0;
        out_valid  = 1'b0;
        out_dir    = 2'b00;
        out_i      = '0;
        out_j      = '0;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (N == 0) ? ST_DONE : ST_RD_CUR;
                end
            end
            ST_RD_CUR: begin
                ram_en     = 1'b1;
                rd_i       = i;
                rd_j       = j;
                addr_a     = i - IW'(1);
                addr_b     = j - IW'(1);
                state_next = ST_RD_DIAG;
            end
            ST_RD_DIAG: begin
                ram_en     = 1'b1;
                rd_i       = i - IW'(1);
                rd_j       = j - IW'(1);
                state_next = ST_RD_UP;
            end
            ST_RD_UP: begin
                ram_en     = 1'b1;
                rd_i       = i - IW'(1);
                rd_j       = j;
                state_next = ST_RD_LEFT;
            end
            ST_RD_LEFT: begin
                ram_en     = 1'b1;
                rd_i       = i;
                rd_j       = j - IW'(1);
                state_next = ST_WAIT;
            end
            ST_WAIT:   state_next = ST_DECIDE;
            ST_DECIDE: state_next = ST_EMIT;
            ST_BORDER: state_next = ST_EMIT;
            ST_EMIT: begin
                out_valid = 1'b1;
                out_dir   = dir_r;
                out_i     = i;
                out_j     = j;
                if (out_ready) begin
                    if ((ni == '0) && (nj == '0)) begin
                        state_next = ST_DONE;
                    end else if ((ni == '0) || (nj == '0)) begin
                        state_next = ST_BORDER;
                    end else begin
                        state_next = ST_RD_CUR;
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign ram_addr = AW'(32'(rd_i) * 32'(N + 1) + 32'(rd_j));

    // Datapath: cell indices, captured read data, chosen direction and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            i      <= '0;
            j      <= '0;
            cur_r  <= '0;
            diag_r <= '0;
            up_r   <= '0;
            left_r <= '0;
            same_r <= 1'b0;
            dir_r  <= 2'b00;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i   <= IW'(N);
                        j   <= IW'(N);
                        err <= 1'b0;
                    end
                end
                ST_RD_DIAG: begin
                    cur_r  <= ram_dout;
                    same_r <= (char_a == char_b);
                end
                ST_RD_UP:   diag_r <= ram_dout;
                ST_RD_LEFT: up_r   <= ram_dout;
                ST_WAIT:    left_r <= ram_dout;
                ST_DECIDE: begin
                    dir_r <= dec_dir;
                    if (dec_err) begin
                        err <= 1'b1;
                    end
                end
                ST_BORDER: dir_r <= (i == '0) ? DIR_LEFT : DIR_UP;
                ST_EMIT: begin
                    if (out_ready) begin
                        i <= ni;
                        j <= nj;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_reader.sv
// tb/tb_traceback_reader.sv - self-checking bench for traceback_reader
module tb_traceback_reader;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              ram_en;
    logic [5:0]        ram_addr;
    logic signed [8:0] ram_dout = '0;
    logic [3:0]        addr_a;
    logic [3:0]        addr_b;
    logic [1:0]        char_a = '0;
    logic [1:0]        char_b = '0;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_dir;
    logic [3:0]        out_i;
    logic [3:0]        out_j;

    traceback_reader #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .addr_a(addr_a), .addr_b(addr_b), .char_a(char_a), .char_b(char_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
        .out_i(out_i), .out_j(out_j)
    );

    always #5 clk = ~clk;

    logic signed [8:0] mem [0:63];
    logic [1:0]        sa [0:15];
    logic [1:0]        sb [0:15];

    // Score RAM and sequence RAMs, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
        char_a <= sa[addr_a];
        char_b <= sb[addr_b];
    end

    typedef struct {
        int dir;
        int i;
        int j;
    } step_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         bad_idx;
        int         bad_val;
        int         exp_steps;
        int         exp_dir;
        int         exp_err;
    } vec_t;

    step_t exp_q[$];
    int    exp_err;
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx(input int i, input int j);
        return i * (N + 1) + j;
    endfunction

    task automatic fill_matrix(input logic [7:0] a, input logic [7:0] b);
        int f [0:N][0:N];
        int s;
        int best;
        for (int k = 0; k < 16; k++) begin
            sa[k] = 2'b00;
            sb[k] = 2'b00;
        end
        for (int k = 0; k < 64; k++) mem[k] = '0;
        for (int k = 0; k < N; k++) begin
            sa[k] = a[2*k +: 2];
            sb[k] = b[2*k +: 2];
        end
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j <= N; j++) begin
                if (i == 0) f[i][j] = -2 * j;
                else if (j == 0) f[i][j] = -2 * i;
                else begin
                    s = (sa[i-1] == sb[j-1]) ? 1 : -1;
                    best = f[i-1][j-1] + s;
                    if (f[i-1][j] - 2 > best) best = f[i-1][j] - 2;
                    if (f[i][j-1] - 2 > best) best = f[i][j-1] - 2;
                    f[i][j] = best;
                end
                mem[idx(i, j)] = 9'(f[i][j]);
            end
        end
    endtask

    task automatic push_step(input int d, input int i, input int j);
        step_t s;
        s.dir = d;
        s.i = i;
        s.j = j;
        exp_q.push_back(s);
    endtask

    task automatic build_model();
        int i;
        int j;
        int s;
        int c;
        int dg;
        int up;
        int lf;
        exp_q.delete();
        exp_err = 0;
        i = N;
        j = N;
        while (i > 0 || j > 0) begin
            if (i == 0) begin
                push_step(3, i, j);
                j--;
            end else if (j == 0) begin
                push_step(2, i, j);
                i--;
            end else begin
                s  = (sa[i-1] == sb[j-1]) ? 1 : -1;
                c  = mem[idx(i, j)];
                dg = mem[idx(i-1, j-1)];
                up = mem[idx(i-1, j)];
                lf = mem[idx(i, j-1)];
                if (c == dg + s) begin
                    push_step(1, i, j);
                    i--;
                    j--;
                end else if (c == up - 2) begin
                    push_step(2, i, j);
                    i--;
                end else begin
                    if (c != lf - 2) exp_err = 1;
                    push_step(3, i, j);
                    j--;
                end
            end
        end
    endtask

    task automatic run_case(input logic [7:0] a, input logic [7:0] b, input int bad_idx,
                            input int bad_val, input int mode,
                            output int nsteps, output int first_lat, output int first_dir);
        int         cyc;
        int         stall;
        int         last_xfer;
        bit         prev_hold;
        logic [1:0] h_dir;
        logic [3:0] h_i;
        logic [3:0] h_j;
        step_t      s;
        fill_matrix(a, b);
        if (bad_idx >= 0) mem[bad_idx] = 9'(bad_val);
        build_model();
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_on_start", busy, 1);
        check("err_clear_on_start", err, 0);
        nsteps = 0;
        first_lat = -1;
        first_dir = -1;
        stall = 5;
        last_xfer = 0;
        prev_hold = 1'b0;
        h_dir = '0;
        h_i = '0;
        h_j = '0;
        while (!done && cyc < 800) begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_dir", out_dir, h_dir);
                check("hold_i", out_i, h_i);
                check("hold_j", out_j, h_j);
            end
            if (out_valid) begin
                if (first_lat < 0) first_lat = cyc;
                check("ram_en_in_emit", ram_en, 0);
                if (mode == 2 && stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else if (mode == 1) begin
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    if (nsteps < exp_q.size()) begin
                        s = exp_q[nsteps];
                        check("step_dir", out_dir, s.dir);
                        check("step_i", out_i, s.i);
                        check("step_j", out_j, s.j);
                        if (mode == 0 && nsteps > 0)
                            check("step_gap", cyc - last_xfer, (s.i == 0 || s.j == 0) ? 2 : 7);
                    end else begin
                        check("extra_step", nsteps, exp_q.size());
                    end
                    if (nsteps == 0) first_dir = out_dir;
                    last_xfer = cyc;
                    nsteps++;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    h_dir = out_dir;
                    h_i = out_i;
                    h_j = out_j;
                end
            end else begin
                prev_hold = 1'b0;
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (done) check("done_after_last", cyc - last_xfer, 1);
        else check("done_timeout", 0, 1);
        check("step_count_model", nsteps, exp_q.size());
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("err_vs_model", err, exp_err);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [5];
        int   ns;
        int   fl;
        int   fd;
        int   cyc;
        int   bi;
        int   bv;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{a: 8'hE4, b: 8'hE4, bad_idx: -1, bad_val: 0,   exp_steps: 4, exp_dir: 1, exp_err: 0};
        vecs[1] = '{a: 8'h00, b: 8'h55, bad_idx: -1, bad_val: 0,   exp_steps: 4, exp_dir: 1, exp_err: 0};
        vecs[2] = '{a: 8'hE4, b: 8'h39, bad_idx: -1, bad_val: 0,   exp_steps: 5, exp_dir: 3, exp_err: 0};
        vecs[3] = '{a: 8'h39, b: 8'hE4, bad_idx: -1, bad_val: 0,   exp_steps: 5, exp_dir: 2, exp_err: 0};
        vecs[4] = '{a: 8'hE4, b: 8'hE4, bad_idx: 24, bad_val: 100, exp_steps: 5, exp_dir: 3, exp_err: 1};

        rst = 1'b0;
        start = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = '0;
        for (int k = 0; k < 16; k++) begin
            sa[k] = '0;
            sb[k] = '0;
        end

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs_zero",
                  {busy, done, err, ram_en, out_valid, out_dir, out_i, out_j, ram_addr, addr_a, addr_b}, 0);
        end
        rst = 1'b1;
        start = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_case(vecs[v].a, vecs[v].b, vecs[v].bad_idx, vecs[v].bad_val, (v == 0) ? 2 : 0, ns, fl, fd);
            check("vec_steps", ns, vecs[v].exp_steps);
            check("vec_first_dir", fd, vecs[v].exp_dir);
            check("vec_err", err, vecs[v].exp_err);
            check("vec_first_latency", fl, 7);
        end

        repeat (3) @(negedge clk);
        check("err_sticky_idle", err, 1);

        fill_matrix(8'hE4, 8'hE4);
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("midrun_ram_en", ram_en, 1);
        check("midrun_up_addr", ram_addr, idx(2, 3));
        rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_zero",
              {busy, done, err, ram_en, out_valid, out_dir, out_i, out_j, ram_addr, addr_a, addr_b}, 0);
        rst = 1'b1;
        out_ready = 1'b0;
        run_case(8'hE4, 8'hE4, -1, 0, 0, ns, fl, fd);
        check("restart_steps", ns, 4);
        check("restart_first_latency", fl, 7);

        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            bi = -1;
            bv = 0;
            if ($urandom_range(0, 3) == 0) begin
                bi = idx($urandom_range(1, N), $urandom_range(1, N));
                bv = $urandom_range(0, 40) - 20;
            end
            run_case(ra, rb, bi, bv, 1, ns, fl, fd);
            check("rand_step_bound", (ns >= N && ns <= 2 * N) ? 1 : 0, 1);
            check("rand_first_latency", fl, 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traceback_reader.md
# traceback_reader

Reads the completed Needleman-Wunsch score matrix back out of the score RAM and walks it from cell (N,N) to (0,0), emitting one alignment step per move. It is the consumer of the score matrix that the score-writing side fills. It drives the RAM read port and the two sequence-RAM read ports, recomputes each cell's predecessor, and streams steps out through a valid/ready handshake to the alignment builder.

## Interface

**Parameters**
- N, 128, sequence length.
- BitAddr, $clog2(N+1), index width is BitAddr+1 bits.
- addr_lenght, $clog2(((N+1)*(N+1))-1), RAM address width is addr_lenght+1 bits.
- MATCH, 1, match score (signed 9-bit).
- MISMATCH, -1, mismatch score.
- GAP, -2, gap score.

**Ports**
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin traceback; sampled only in IDLE.
- busy  out  1  high from start acceptance until DONE is left.
- done  out  1  one-cycle pulse when (0,0) is reached.
- err  out  1  sticky; set when no predecessor equation holds; cleared by reset or start.
- ram_en  out  1  read enable for the score RAM.
- ram_addr  out  addr_lenght+1  score address, i*(N+1)+j.
- ram_dout  in  signed 9  score data, 1-cycle read latency.
- addr_a, addr_b  out  BitAddr+1  sequence addresses i-1 and j-1.
- char_a, char_b  in  2  nucleotide codes, 1-cycle latency.
- out_valid  out  1  step available.
- out_ready  in  1  consumer accepts the step.
- out_dir  out  2  01 = diag, 10 = up (gap in b), 11 = left (gap in a).
- out_i, out_j  out  BitAddr+1  cell the step leaves from.

## Operation

**State machine:** IDLE, RD_CUR, RD_DIAG, RD_UP, RD_LEFT, WAIT, DECIDE, BORDER, EMIT, DONE.

- **IDLE:** start=1 loads i=N, j=N, clears err, sets busy, then goes to RD_CUR, or to DONE if N=0.
- **Interior cell (i>0, j>0):**
  - Reads are issued on consecutive cycles with ram_en=1: cur (i,j) in RD_CUR, diag (i-1,j-1) in RD_DIAG, up (i-1,j) in RD_UP, left (i,j-1) in RD_LEFT.
  - addr_a/addr_b are driven in RD_CUR. Each datum is registered the cycle after its address is issued; left is captured in WAIT.
- **DECIDE:** uses signed 10-bit arithmetic on the registered values. Checks in priority order:
  - cur == diag + (char_a==char_b ? MATCH : MISMATCH) → diag
  - else cur == up + GAP → up
  - else cur == left + GAP → left
  - else left, and set err.
- **Border cell:**
  - i==0, j>0: BORDER emits left.
  - j==0, i>0: BORDER emits up.
  - No RAM reads are issued for border cells.
- **EMIT:**
  - out_valid=1 with out_dir/out_i/out_j from the current cell.
  - On out_valid && out_ready: update i,j (diag: both −1; up: i−1; left: j−1).
  - Next state is DONE if the new (i,j)=(0,0), BORDER if the new i==0 or j==0, otherwise RD_CUR.
- **DONE:** done=1 for one cycle, busy drops, return to IDLE.
- **Step count:** total steps lie between N and 2N inclusive.

## Timing

- **Reset values:** state IDLE; busy, done, err, ram_en, out_valid = 0; out_dir, out_i, out_j, ram_addr, addr_a, addr_b = 0. Reset (rst=0) at any cycle aborts the traceback.
- **Start latency:** start in IDLE → busy=1 and state RD_CUR on the next cycle.
- **Interior step:** 6 cycles from RD_CUR entry to out_valid=1 (RD_CUR, RD_DIAG, RD_UP, RD_LEFT, WAIT, DECIDE, then EMIT).
- **Border step:** 1 cycle (BORDER, then EMIT).
- **Handshake:**
  - out_valid stays high and out_dir/out_i/out_j stay stable until out_ready=1.
  - out_valid never drops without a transfer.
  - out_ready is ignored when out_valid=0.
- **Ignored start:** start while busy is ignored.
- **ram_en:** high only in the four RD_* states.

## Test plan

- **Reset check:** hold rst=0 for 3 cycles with start=1 → all outputs 0, busy stays 0.
- **Identical sequences:** N=4, a=b=ACGT, matrix from golden model with cur(4,4)=4 → steps diag (4,4),(3,3),(2,2),(1,1); done pulses 1 cycle after the last transfer; err=0; first out_valid 7 cycles after start.
- **Gap path:** N=4, a=AAAA, b=CCCC, golden matrix → step sequence matches golden traceback with diag>up>left tie priority; border steps 1 cycle apart when out_ready=1.
- **Backpressure:** out_ready=0 for 5 cycles during the first EMIT → out_valid held and out_dir/out_i/out_j unchanged; ram_en=0 throughout the stall.
- **Corrupted cell:** set cur(4,4)=100 → first step left from (4,4), err=1 and sticky until the next start.
- **Reset mid-run:** assert rst=0 during RD_UP of the second step, then start → outputs 0 the cycle after reset; the new run restarts from (4,4) and reproduces the full golden sequence.
